// File: rtl/accel_dot_pkg.sv
// Shared types and helpers for the accel_dot_lanes matrix-vector engine.
//   state_e : engine FSM states
//   data_t  : signed 32-bit stream element / weight
//   acc_t   : signed 64-bit lane accumulator
//   sum_t   : widened cross-lane sum (guard bits keep the sign correct
//             when several near-full-scale lane accumulators are added)
//   sat32() : clamp a cross-lane sum into the signed 32-bit range
package accel_dot_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_MAC    = 2'd1,
    ST_REDUCE = 2'd2,
    ST_SEND   = 2'd3
  } state_e;

  typedef logic signed [31:0] data_t;
  typedef logic signed [63:0] acc_t;

  localparam int SUM_W = 72;
  typedef logic signed [SUM_W-1:0] sum_t;

  localparam data_t DATA_MAX = 32'sh7FFF_FFFF;
  localparam data_t DATA_MIN = 32'sh8000_0000;

  function automatic data_t sat32(input sum_t v);
    if (v > sum_t'(DATA_MAX))      return DATA_MAX;
    else if (v < sum_t'(DATA_MIN)) return DATA_MIN;
    else                           return data_t'(v[31:0]);
  endfunction

endpackage

// File: rtl/accel_dot_lanes_lane.sv
// dot_lane: one multiply-accumulate lane.
//   clk   : clock
//   rst   : synchronous active-high reset (clears the accumulator)
//   clr_i : clear accumulator (takes priority over en_i)
//   en_i  : accumulate a_i * b_i this cycle
//   a_i   : signed 32-bit weight
//   b_i   : signed 32-bit input element
//   acc_o : signed 64-bit running sum
module dot_lane
  import accel_dot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] acc_o
);

  acc_t prod;
  acc_t acc_q, acc_d;

  // Full 64-bit signed product; a 32x32 product always fits.
  assign prod = acc_t'($signed(a_i)) * acc_t'($signed(b_i));

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/accel_dot_lanes.sv
// accel_dot_lanes: streams in an input vector x (COLS elements), then emits
// y[r] = sum_c weights[r][c] * x[c] for r = 0..ROWS-1 as an output stream.
// Each row is computed by LANES parallel dot_lane MACs over K = COLS/LANES
// cycles, reduced in one cycle, then held on the output until accepted.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   INPUT_AXIS_TDATA/TLAST/
//   TVALID / TREADY          : input vector stream (signed 32-bit)
//   weights                  : [ROWS][COLS] signed 32-bit, static per vector
//   OUTPUT_AXIS_TDATA/TLAST/
//   TVALID / TREADY          : result stream, TLAST on the last row
//   busy                     : high whenever not loading
//
// Build option: define ACCEL_DOT_SATURATE_EN to clamp each result to the
// signed 32-bit range; otherwise the result wraps modulo 2^32.
module accel_dot_lanes
  import accel_dot_pkg::*;
#(
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  parameter int LANES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       INPUT_AXIS_TDATA,
  input  logic                              INPUT_AXIS_TLAST,
  input  logic                              INPUT_AXIS_TVALID,
  output logic                              INPUT_AXIS_TREADY,
  input  logic [ROWS-1:0][COLS-1:0][31:0]   weights,
  output logic [31:0]                       OUTPUT_AXIS_TDATA,
  output logic                              OUTPUT_AXIS_TLAST,
  output logic                              OUTPUT_AXIS_TVALID,
  input  logic                              OUTPUT_AXIS_TREADY,
  output logic                              busy
);

  generate
    if (LANES < 1 || (COLS % LANES) != 0) begin : g_bad_cfg
      $error("accel_dot_lanes: COLS must be a multiple of LANES and LANES >= 1");
    end
  endgenerate

  localparam int K  = COLS / LANES;
  localparam int KW = (K > 1)    ? $clog2(K)    : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e                  state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [KW-1:0]           k_q, k_d;
  logic [COLS-1:0][31:0]   x_q, x_d;
  logic [31:0]             result_q, result_d;

  logic                    in_ready;
  logic                    accept;
  logic                    last_word;
  logic                    lane_clr;
  logic                    lane_en;
  logic [LANES-1:0][63:0]  lane_acc;
  sum_t                    red_sum;

  // Outputs are forced quiet while rst is held, not just after the edge.
  assign in_ready  = (state_q == ST_LOAD) && !rst;
  assign accept    = INPUT_AXIS_TVALID && in_ready;
  assign last_word = INPUT_AXIS_TLAST || (idx_q == CW'(COLS - 1));

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    idx_d    = idx_q;
    k_d      = '0;
    x_d      = x_q;
    result_d = result_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          // Zeroing the not-yet-written slots on every accept means an early
          // TLAST leaves the tail of x at zero without a separate clear pass.
          for (int i = 0; i < COLS; i++) begin
            if (CW'(i) == idx_q)     x_d[i] = INPUT_AXIS_TDATA;
            else if (CW'(i) > idx_q) x_d[i] = '0;
          end
          idx_d = idx_q + 1'b1;
          if (last_word) begin
            idx_d   = '0;
            state_d = ST_MAC;
          end
        end
      end
      ST_MAC: begin
        k_d = k_q + 1'b1;
        if (k_q == KW'(K - 1)) begin
          k_d     = '0;
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
`ifdef ACCEL_DOT_SATURATE_EN
        result_d = sat32(red_sum);
`else
        result_d = red_sum[31:0];
`endif
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (OUTPUT_AXIS_TREADY) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_MAC;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      row_q    <= '0;
      idx_q    <= '0;
      k_q      <= '0;
      x_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      x_q      <= x_d;
      result_q <= result_d;
    end
  end

  // Accumulators clear on the edge that enters MAC, so the first MAC cycle
  // already starts from zero.
  assign lane_clr = (state_q != ST_MAC) && (state_d == ST_MAC);
  assign lane_en  = (state_q == ST_MAC);

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [CW-1:0] col;
      assign col = CW'(l * K) + CW'(k_q);

      dot_lane u_lane (
        .clk   (clk),
        .rst   (rst),
        .clr_i (lane_clr),
        .en_i  (lane_en),
        .a_i   (weights[row_q][col]),
        .b_i   (x_q[col]),
        .acc_o (lane_acc[l])
      );
    end
  endgenerate

  always_comb begin
    red_sum = '0;
    for (int l = 0; l < LANES; l++) red_sum = red_sum + sum_t'($signed(lane_acc[l]));
  end

  assign INPUT_AXIS_TREADY  = in_ready;
  assign OUTPUT_AXIS_TVALID = (state_q == ST_SEND) && !rst;
  assign OUTPUT_AXIS_TDATA  = OUTPUT_AXIS_TVALID ? result_q : '0;
  assign OUTPUT_AXIS_TLAST  = OUTPUT_AXIS_TVALID && (row_q == RW'(ROWS - 1));
  assign busy               = (state_q != ST_LOAD) && !rst;

endmodule

// File: tb/tb_accel_dot_lanes.sv
// Directed bench for accel_dot_lanes: three instances at LANES=1,2,4
// (ROWS=3, COLS=4) share the weight matrix; vectors come from a table with
// hand-computed results, plus hand-written stall / hold / reset / overflow
// sequences on the LANES=2 instance.
module tb_accel_dot_lanes;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0][3:0][31:0] w;
  logic [31:0] in_data  [3];
  logic        in_last  [3];
  logic        in_valid [3];
  logic        in_ready [3];
  logic [31:0] out_data [3];
  logic        out_last [3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic        busy     [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    accel_dot_lanes #(.ROWS(3), .COLS(4), .LANES(1 << g)) u_dut (
      .clk                (clk),
      .rst                (rst),
      .INPUT_AXIS_TDATA   (in_data[g]),
      .INPUT_AXIS_TLAST   (in_last[g]),
      .INPUT_AXIS_TVALID  (in_valid[g]),
      .INPUT_AXIS_TREADY  (in_ready[g]),
      .weights            (w),
      .OUTPUT_AXIS_TDATA  (out_data[g]),
      .OUTPUT_AXIS_TLAST  (out_last[g]),
      .OUTPUT_AXIS_TVALID (out_valid[g]),
      .OUTPUT_AXIS_TREADY (out_ready[g]),
      .busy               (busy[g])
    );
  end

  typedef struct {
    int n;
    int x[4];
    bit tl;
    int e[3];
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present n words; leaves the last word driven during its accept cycle.
  task automatic send(input int d, input int n, input int xs[4], input bit tl,
                      output int t_acc);
    int wt;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_data[d]  = xs[i];
      in_last[d]  = tl && (i == n - 1);
      wt = 0;
      while (!in_ready[d] && wt < 100) begin
        @(negedge clk);
        wt++;
      end
      chk("accept_wait", longint'(wt < 100), 1);
    end
    t_acc = cyc;
  endtask

  // Collect the three rows, checking value, TLAST, latency, stall stability
  // and that the input side stays closed throughout.
  task automatic collect(input int d, input int e0, input int e1, input int e2,
                         input int stall, input int t_acc, input bit drop_in,
                         output int h_last);
    int k;
    int t_ref;
    int wt;
    int ex[3];
    bit rdy_bad;
    bit stable;
    logic [31:0] dh;
    logic lh;
    k = 4 >> d;
    t_ref = t_acc;
    rdy_bad = 1'b0;
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    for (int r = 0; r < 3; r++) begin
      wt = 0;
      do begin
        @(negedge clk);
        if (drop_in && r == 0 && wt == 0) in_valid[d] = 1'b0;
        out_ready[d] = (stall == 0);
        if (in_ready[d]) rdy_bad = 1'b1;
        wt++;
      end while (!out_valid[d] && wt < 100);
      chk("valid_seen", longint'(out_valid[d]), 1);
      chk(r == 0 ? "first_latency" : "row_latency", cyc, t_ref + k + 2);
      chk("row_data", longint'($signed(out_data[d])), ex[r]);
      chk("row_last", longint'(out_last[d]), (r == 2) ? 1 : 0);
      if (stall > 0) begin
        dh = out_data[d];
        lh = out_last[d];
        stable = 1'b1;
        repeat (stall) begin
          @(negedge clk);
          if (!out_valid[d] || out_data[d] !== dh || out_last[d] !== lh) stable = 1'b0;
          if (in_ready[d]) rdy_bad = 1'b1;
        end
        chk("stall_hold", longint'(stable), 1);
        out_ready[d] = 1'b1;
      end
      t_ref = cyc;
    end
    chk("in_ready_closed", longint'(rdy_bad), 0);
    @(negedge clk);
    chk("post_valid", longint'(out_valid[d]), 0);
    chk("post_in_ready", longint'(in_ready[d]), 1);
    h_last = t_ref;
  endtask

  initial begin
    int wt_i[3][4];
    int t;
    int h;
    int wt;
    int sx[4];
    int sat_exp;

    wt_i = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, 0, 1, 0}};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) w[r][c] = wt_i[r][c];

    tbl[0] = '{4, '{1, 1, 1, 1},   1'b1, '{10, 26, 0}};
    tbl[1] = '{2, '{2, 3, 0, 0},   1'b1, '{8, 28, -2}};
    tbl[2] = '{4, '{1, 2, 3, 4},   1'b1, '{30, 70, 2}};
    tbl[3] = '{4, '{-1, 2, -3, 4}, 1'b1, '{10, 18, -2}};
    tbl[4] = '{1, '{5, 0, 0, 0},   1'b1, '{5, 25, -5}};
    tbl[5] = '{4, '{3, 0, 0, 7},   1'b0, '{31, 71, -3}};

    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_last[d] = 1'b0; out_ready[d] = 1'b1;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  longint'(in_ready[1]), 0);
    chk("rst_out_valid", longint'(out_valid[1]), 0);
    chk("rst_out_data",  longint'(out_data[1]), 0);
    chk("rst_out_last",  longint'(out_last[1]), 0);
    chk("rst_busy",      longint'(busy[1]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", longint'(in_ready[1]), 1);

    // Table vectors on every lane count
    for (int d = 0; d < 3; d++) begin
      for (int v = 0; v < 6; v++) begin
        send(d, tbl[v].n, tbl[v].x, tbl[v].tl, t);
        collect(d, tbl[v].e[0], tbl[v].e[1], tbl[v].e[2], 0, t, 1'b1, h);
      end
    end

    // Output stalls of 5 cycles on every row
    send(1, tbl[2].n, tbl[2].x, 1'b1, t);
    collect(1, 30, 70, 2, 5, t, 1'b1, h);

    // A 5th word without TLAST waits until the next LOAD
    send(1, 4, tbl[5].x, 1'b0, t);
    @(negedge clk);
    in_data[1] = 9; in_last[1] = 1'b1; in_valid[1] = 1'b1;
    collect(1, 31, 71, -3, 0, t, 1'b0, h);
    collect(1, 9, 45, -9, 0, h + 1, 1'b1, h);

    // Reset during row-1 SEND, then a clean vector
    send(1, tbl[2].n, tbl[2].x, 1'b1, t);
    @(negedge clk);
    in_valid[1] = 1'b0;
    wt = 0;
    while (!out_valid[1] && wt < 100) begin @(negedge clk); wt++; end
    chk("rst_seq_row0", longint'($signed(out_data[1])), 30);
    @(negedge clk);
    wt = 0;
    while (!out_valid[1] && wt < 100) begin @(negedge clk); wt++; end
    chk("rst_seq_row1", longint'($signed(out_data[1])), 70);
    out_ready[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", longint'(out_valid[1]), 0);
    chk("midrst_last",  longint'(out_last[1]), 0);
    chk("midrst_busy",  longint'(busy[1]), 0);
    rst = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("midrst_ready", longint'(in_ready[1]), 1);
    chk("midrst_no_stale", longint'(out_valid[1]), 0);
    send(1, tbl[0].n, tbl[0].x, 1'b1, t);
    collect(1, 10, 26, 0, 0, t, 1'b1, h);

    // Full-scale operands
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) w[r][c] = 32'h7FFF_FFFF;
    for (int i = 0; i < 4; i++) sx[i] = 32'h7FFF_FFFF;
`ifdef ACCEL_DOT_SATURATE_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 4;
`endif
    send(1, 4, sx, 1'b1, t);
    collect(1, sat_exp, sat_exp, sat_exp, 0, t, 1'b1, h);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
